// File: rtl/uart_tx_sched.sv
// Memory-mapped UART transmit scheduler: CPU writes fill a byte FIFO that drains into the
// emitter over a valid/ready handshake, with sticky overflow status and a drained interrupt.
module uart_tx_sched #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

  state_e                state_q, state_d;
  logic [7:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  overflow_q, enable_q, irq_en_q, irq_q;
  logic [31:0]           rdata_q, rdata_d, status;
  logic [7:0]            tx_data_q;

  logic       wr_en, rd_en, flush, push_req, push, pop, load, full, empty, busy;
  logic [1:0] reg_sel;
  logic       unused_bits;

  assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:8]};

  assign reg_sel  = addr[3:2];
  assign wr_en    = sel & we;
  assign rd_en    = sel & ~we;
  assign flush    = wr_en & (reg_sel == 2'd1) & wdata[2];
  assign push_req = wr_en & (reg_sel == 2'd2);
  assign full     = (count_q == CntW'(Depth));
  assign empty    = (count_q == '0);
  // A push coinciding with a flush is discarded without flagging overflow.
  assign push     = push_req & ~flush & ~full;
  // Guard covers a flush landing on the IDLE->LOAD edge, leaving LOAD with an empty FIFO.
  assign pop      = load & ~empty;
  assign busy     = ~empty | (state_q != StIdle);

  // FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata[7:0];
  end

  always_comb begin
    count_d = count_q;
    if (flush)              count_d = '0;
    else if (push && !pop)  count_d = count_q + CntW'(1);
    else if (!push && pop)  count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      end
    end
  end

  // Drain FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable_q && !empty) state_d = StLoad;
      StLoad:  state_d = StSend;
      StSend:  if (tx_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    load     = (state_q == StLoad);
    tx_valid = (state_q == StSend);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   tx_data_q <= '0;
    else if (load) tx_data_q <= mem_q[rd_ptr_q];
  end

  // Control/status registers and read port
  always_comb begin
    status                   = '0;
    status[0]                = busy;
    status[1]                = full;
    status[2]                = empty;
    status[3]                = overflow_q;
    status[DEPTH_LOG2+8:8]   = count_q;
  end

  always_comb begin
    case (reg_sel)
      2'd0:    rdata_d = status;
      2'd1:    rdata_d = {30'b0, irq_en_q, enable_q};
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow_q <= 1'b0;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (push_req && !flush && full)                        overflow_q <= 1'b1;
      else if (wr_en && (reg_sel == 2'd0) && wdata[3])       overflow_q <= 1'b0;
      if (wr_en && (reg_sel == 2'd1)) begin
        enable_q <= wdata[0];
        irq_en_q <= wdata[1];
      end
      if (rd_en) rdata_q <= rdata_d;
      irq_q <= irq_en_q & empty & (state_q == StIdle);
    end
  end

  assign rdata   = rdata_q;
  assign tx_data = tx_data_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: expected bytes and read data are queued at stimulus time
// and popped by a negedge monitor whenever the DUT hands off a byte or returns read data.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        sel, we, tx_ready;
  logic [31:0] addr, wdata, rdata;
  logic [7:0]  tx_data;
  logic        tx_valid, irq;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  tx_q[$];
  logic [31:0] rd_q[$];
  string       rd_name_q[$];
  logic        rd_seen = 1'b0;

  always #5 clk = ~clk;

  uart_tx_sched #(.DEPTH_LOG2(4)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .sel      (sel),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .irq      (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = 32'(idx) << 2; wdata = d;
    tick();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input int idx, input logic [31:0] exp, input string name);
    sel = 1'b1; we = 1'b0; addr = 32'(idx) << 2;
    rd_q.push_back(exp);
    rd_name_q.push_back(name);
    tick();
    sel = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input bit expect_out);
    if (expect_out) tx_q.push_back(d);
    wr(2, {24'b0, d});
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (tx_q.size() == 0 && !tx_valid) done = 1'b1;
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 50 && !tx_valid; i++) tick();
    check(name, 32'(tx_valid), 32'd1);
  endtask

  always @(posedge clk) rd_seen <= sel && !we && resetn;

  // Monitor: rdata is valid the cycle after a read strobe; a byte leaves on valid & ready.
  always @(negedge clk) begin
    if (rd_seen) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        $display("FAIL rd_unexpected: got 0x%08h, want no read", rdata);
      end else begin
        check(rd_name_q.pop_front(), rdata, rd_q.pop_front());
      end
    end
    if (resetn && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        n_checks++;
        $display("FAIL tx_unexpected: got 0x%02h, want no handshake", tx_data);
      end else begin
        check("tx_byte", {24'b0, tx_data}, {24'b0, tx_q.pop_front()});
      end
    end
  end

  initial begin
    sel = 1'b0; we = 1'b0; addr = '0; wdata = '0; tx_ready = 1'b0;
    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    tick();

    // Reset state
    check("tx_valid_reset", 32'(tx_valid), 32'd0);
    check("irq_reset", 32'(irq), 32'd0);
    rd(0, 32'h0000_0004, "status_reset");
    rd(1, 32'h0000_0000, "ctrl_reset");

    // In-order drain with tx_ready held high
    tx_ready = 1'b1;
    wr(1, 32'h1);
    push(8'h41, 1'b1);
    push(8'h42, 1'b1);
    push(8'h43, 1'b1);
    wait_drain("drain_abc");
    rd(0, 32'h0000_0004, "status_after_abc");

    // Fill past full while disabled: 16 kept, 17th dropped with overflow
    tx_ready = 1'b0;
    wr(1, 32'h0);
    for (int i = 0; i < 17; i++) push(8'(8'h50 + i), 1'b0);
    rd(0, 32'h0000_100B, "status_full_ovf");
    wr(0, 32'h8);
    rd(0, 32'h0000_1003, "status_ovf_clear");
    for (int i = 0; i < 16; i++) tx_q.push_back(8'(8'h50 + i));
    tx_ready = 1'b1;
    wr(1, 32'h1);
    wait_drain("drain_full");
    rd(0, 32'h0000_0004, "status_after_full");

    // Flush while a byte is stuck in SEND
    tx_ready = 1'b0;
    push(8'h61, 1'b1);
    push(8'h62, 1'b0);
    push(8'h63, 1'b0);
    wait_valid("valid_before_flush");
    rd(0, 32'h0000_0201, "status_before_flush");
    wr(1, 32'h5);
    rd(0, 32'h0000_0005, "status_after_flush");
    rd(1, 32'h0000_0001, "ctrl_flush_selfclear");
    check("valid_held_flush", 32'(tx_valid), 32'd1);
    check("data_stable_flush", {24'b0, tx_data}, 32'h61);
    tx_ready = 1'b1;
    repeat (6) tick();
    check("no_valid_after_flush", 32'(tx_valid), 32'd0);

    // Drained interrupt
    wr(1, 32'h3);
    tick();
    check("irq_idle_empty", 32'(irq), 32'd1);
    push(8'h71, 1'b1);
    push(8'h72, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("irq_busy", 32'(irq), 32'd0);
    end
    check("valid_low_drained", 32'(tx_valid), 32'd0);
    tick();
    check("irq_rise", 32'(irq), 32'd1);
    wr(1, 32'h1);
    check("irq_hold_one_cycle", 32'(irq), 32'd1);
    tick();
    check("irq_fall", 32'(irq), 32'd0);

    // Asynchronous reset mid-SEND
    tx_ready = 1'b0;
    push(8'h81, 1'b0);
    wait_valid("valid_before_reset");
    #2 resetn = 1'b0;
    #1 check("valid_async_reset", 32'(tx_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    tx_ready = 1'b1;
    tick();
    rd(0, 32'h0000_0004, "status_after_reset");
    rd(1, 32'h0000_0000, "ctrl_after_reset");
    repeat (4) tick();
    check("valid_idle_after_reset", 32'(tx_valid), 32'd0);

    check("tx_queue_empty", 32'(tx_q.size()), 32'd0);
    check("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
